fourth_step: RTL

MEM stage of the five-stage MIPS pipeline, directly downstream of the execute stage. It latches the execute results into an internal EX/MEM register and performs the data-memory access (byte, half or word; signed or unsigned load). It then latches the result into an internal MEM/WB register for writeback. It also exports the MEM-stage ALU result and destination register for forwarding into execute operand muxes (forward select 01) and for the hazard unit.

---
 rtl/fourth_step_pkg.sv | 61 ++++++
 rtl/fourth_step_data_memory.sv | 32 +++
 rtl/fourth_step.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fourth_step_pkg.sv
// Shared types for the MEM stage: access-size encoding, pipeline register
// layouts and the alignment helpers used by the stage logic.
package fourth_step_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_RSVD = 2'b11
   } mem_size_e;

   typedef struct packed {
      logic [31:0] alu_result;
      logic [31:0] reg2;
      logic [4:0]  write_reg;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
      logic        reg_write;
      mem_size_e   mem_size;
      logic        mem_signed;
   } ex_mem_t;

   typedef struct packed {
      logic        reg_write;
      logic        mem_to_reg;
      logic [31:0] read_data;
      logic [31:0] alu_result;
      logic [4:0]  write_reg;
   } mem_wb_t;

   // A bubble carries no control and zeroed data fields.
   localparam ex_mem_t EX_MEM_BUBBLE = '0;
   localparam mem_wb_t MEM_WB_CLEAR  = '0;

   // Reserved size is reported as misaligned so it can never touch memory.
   function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] lane);
      logic mis;
      mis = 1'b1;
      case (size)
         SIZE_BYTE: mis = 1'b0;
         SIZE_HALF: mis = lane[0];
         SIZE_WORD: mis = |lane;
         default:   mis = 1'b1;
      endcase
      return mis;
   endfunction

   function automatic logic [3:0] lane_enables(input mem_size_e size, input logic [1:0] lane);
      logic [3:0] en;
      en = 4'b0000;
      case (size)
         SIZE_BYTE: en = 4'b0001 << lane;
         SIZE_HALF: en = lane[1] ? 4'b1100 : 4'b0011;
         SIZE_WORD: en = 4'b1111;
         default:   en = 4'b0000;
      endcase
      return en;
   endfunction

endpackage

// File: rtl/fourth_step_data_memory.sv
// Word-organised data RAM with per-byte write enables, one synchronous write
// port and two asynchronous read ports (pipeline load and debug).
module fourth_step_data_memory #(
   parameter int MEM_ADDR_W = 8
) (
   input  logic                  clk,
   input  logic [3:0]            we,
   input  logic [MEM_ADDR_W-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata,
   input  logic [MEM_ADDR_W-1:0] dbg_addr,
   output logic [31:0]           dbg_data
);

   localparam int DEPTH = 1 << MEM_ADDR_W;

   logic [31:0] mem [DEPTH];

   // NOTE: storage arrays carry no reset; clearing them would force a flop
   // implementation and software must not rely on power-up contents anyway.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata    = mem[addr];
   assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/fourth_step.sv
// MEM stage: EX/MEM register, data-memory access with sub-word formatting,
// and MEM/WB register; exposes MEM-stage results for forwarding and hazards.
module fourth_step
   import fourth_step_pkg::*;
#(
   parameter int MEM_ADDR_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [31:0]           ex_aluResult,
   input  logic [31:0]           ex_reg2Out,
   input  logic [4:0]            ex_writeReg,
   input  logic                  ex_memRead,
   input  logic                  ex_memWrite,
   input  logic                  ex_memToReg,
   input  logic                  ex_regWrite,
   input  logic [1:0]            ex_memSize,
   input  logic                  ex_memSigned,
   output logic [31:0]           mem_aluResult,
   output logic [4:0]            mem_writeReg,
   output logic                  mem_regWrite,
   output logic                  mem_misaligned,
   output logic                  wb_regWrite,
   output logic                  wb_memToReg,
   output logic [31:0]           wb_readData,
   output logic [31:0]           wb_aluResult,
   output logic [4:0]            wb_writeReg,
   input  logic [MEM_ADDR_W-1:0] dbg_addr,
   output logic [31:0]           dbg_data
);

   ex_mem_t ex_mem;
   mem_wb_t mem_wb;

   logic [MEM_ADDR_W-1:0] word_addr;
   logic [1:0]            lane;
   logic                  misaligned;
   logic                  store_en;
   logic [3:0]            lane_we;
   logic [31:0]           store_data;
   logic [31:0]           raw_rdata;
   logic [31:0]           load_data;
   logic [7:0]            byte_sel;
   logic [15:0]           half_sel;

   // Upper address bits are ignored, so accesses wrap around the array.
   assign word_addr  = ex_mem.alu_result[MEM_ADDR_W+1:2];
   assign lane       = ex_mem.alu_result[1:0];
   assign misaligned = is_misaligned(ex_mem.mem_size, lane);

   // Reset and stall both suppress the write so a held store lands exactly once.
   assign store_en = ex_mem.mem_write & ~misaligned & ~stall & rst_n;

   // NOTE: every always_comb output gets a default first so no path leaves a
   // value unassigned, which would otherwise infer a latch.
   always_comb begin
      lane_we    = '0;
      store_data = ex_mem.reg2;
      case (ex_mem.mem_size)
         SIZE_BYTE: store_data = {4{ex_mem.reg2[7:0]}};
         SIZE_HALF: store_data = {2{ex_mem.reg2[15:0]}};
         default:   store_data = ex_mem.reg2;
      endcase
      if (store_en) begin
         lane_we = lane_enables(ex_mem.mem_size, lane);
      end
   end

   fourth_step_data_memory #(
      .MEM_ADDR_W (MEM_ADDR_W)
   ) u_dmem (
      .clk      (clk),
      .we       (lane_we),
      .addr     (word_addr),
      .wdata    (store_data),
      .rdata    (raw_rdata),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   always_comb begin
      load_data = '0;
      byte_sel  = raw_rdata[{lane, 3'b000} +: 8];
      half_sel  = raw_rdata[{lane[1], 4'b0000} +: 16];
      if (ex_mem.mem_read && !misaligned) begin
         case (ex_mem.mem_size)
            SIZE_BYTE: load_data = {{24{ex_mem.mem_signed & byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_data = {{16{ex_mem.mem_signed & half_sel[15]}}, half_sel};
            SIZE_WORD: load_data = raw_rdata;
            default:   load_data = '0;
         endcase
      end
   end

   // NOTE: pipeline state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_mem <= EX_MEM_BUBBLE;
      end else if (flush) begin
         ex_mem <= EX_MEM_BUBBLE;
      end else if (!stall) begin
         ex_mem <= '{
            alu_result: ex_aluResult,
            reg2:       ex_reg2Out,
            write_reg:  ex_writeReg,
            mem_read:   ex_memRead,
            mem_write:  ex_memWrite,
            mem_to_reg: ex_memToReg,
            reg_write:  ex_regWrite,
            mem_size:   mem_size_e'(ex_memSize),
            mem_signed: ex_memSigned
         };
      end
   end

   // Flush only bubbles EX/MEM; the instruction already in MEM still retires.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_wb <= MEM_WB_CLEAR;
      end else if (!stall) begin
         mem_wb <= '{
            reg_write:  ex_mem.reg_write,
            mem_to_reg: ex_mem.mem_to_reg,
            read_data:  load_data,
            alu_result: ex_mem.alu_result,
            write_reg:  ex_mem.write_reg
         };
      end
   end

   assign mem_aluResult  = ex_mem.alu_result;
   assign mem_writeReg   = ex_mem.write_reg;
   assign mem_regWrite   = ex_mem.reg_write;
   assign mem_misaligned = (ex_mem.mem_read | ex_mem.mem_write) & misaligned;

   assign wb_regWrite = mem_wb.reg_write;
   assign wb_memToReg = mem_wb.mem_to_reg;
   assign wb_readData = mem_wb.read_data;
   assign wb_aluResult = mem_wb.alu_result;
   assign wb_writeReg = mem_wb.write_reg;

endmodule
